// File: rtl/fifo_rd_stream.sv
// Turns the async FIFO read port (empty / r_en / 1-cycle registered rdata) into a valid/ready stream.
// Optional per-packet o_last generation is compiled in with `define STREAM_LAST_EN.
module fifo_rd_stream #(
  parameter int DATA    = 8,
  parameter int PKT_LEN = 4
) (
  input  logic            rclk,
  input  logic            rrst,
  input  logic            empty,
  input  logic [DATA-1:0] rdata,
  output logic            r_en,
  input  logic            flush,
  output logic            o_valid,
  input  logic            o_ready,
  output logic [DATA-1:0] o_data,
  output logic            o_last,
  output logic [15:0]     o_count
);

  if (PKT_LEN < 1 || PKT_LEN > 255) begin : g_bad_pkt_len
    $error("fifo_rd_stream: PKT_LEN must be in 1..255");
  end

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [DATA-1:0] buf_reg  [2];
  logic [DATA-1:0] buf_next [2];
  logic [1:0]      cnt_reg, cnt_next;
  logic            inflight_reg, inflight_next;
  logic [15:0]     count_reg;

  logic            pop;
  logic            wr;
  logic            flushing;
  logic [2:0]      occ;
  logic [1:0]      tail;

  assign o_valid = (cnt_reg != 2'd0);
  assign o_data  = buf_reg[0];
  assign o_count = count_reg;
  assign pop     = o_valid & o_ready;

  // Space check counts the word already in flight, so returning rdata always has a slot.
  assign occ     = {1'b0, cnt_reg} + {2'b00, inflight_reg} - {2'b00, pop};

  always_comb begin
    state_next = state_reg;
    r_en       = 1'b0;
    flushing   = 1'b0;
    case (state_reg)
      HOLD: state_next = RUN;
      RUN: begin
        r_en = ~empty & (occ < 3'd2);
        if (flush) begin
          flushing   = 1'b1;
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (!flush && !inflight_reg) begin
          state_next = RUN;
        end
      end
      default: state_next = HOLD;
    endcase
  end

  // Words landing while in FLUSH are simply never written.
  assign wr            = inflight_reg & (state_reg == RUN);
  assign tail          = cnt_reg - {1'b0, pop};
  assign inflight_next = r_en & ~empty;

  always_comb begin
    cnt_next = cnt_reg + {1'b0, wr} - {1'b0, pop};
    if (flushing || state_reg == FLUSH) begin
      cnt_next = 2'd0;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_buf
    logic load_wr;
    assign load_wr = wr && (tail == 2'(gi));
    if (gi == 0) begin : g_head
      assign buf_next[gi] = load_wr ? rdata : (pop ? buf_reg[1] : buf_reg[0]);
    end else begin : g_tail
      assign buf_next[gi] = load_wr ? rdata : buf_reg[gi];
    end
  end

  always_ff @(posedge rclk) begin
    if (!rrst) begin
      state_reg    <= HOLD;
      cnt_reg      <= 2'd0;
      inflight_reg <= 1'b0;
      count_reg    <= 16'd0;
      for (int i = 0; i < 2; i++) begin
        buf_reg[i] <= '0;
      end
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      inflight_reg <= inflight_next;
      for (int i = 0; i < 2; i++) begin
        buf_reg[i] <= buf_next[i];
      end
      if (pop) begin
        count_reg <= count_reg + 16'd1;
      end
    end
  end

`ifdef STREAM_LAST_EN
  localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

  logic [7:0] pkt_reg;

  assign o_last = o_valid & (pkt_reg == LAST_IDX);

  always_ff @(posedge rclk) begin
    if (!rrst) begin
      pkt_reg <= 8'd0;
    end else if (flushing || state_reg == FLUSH) begin
      pkt_reg <= 8'd0;
    end else if (pop) begin
      pkt_reg <= o_last ? 8'd0 : pkt_reg + 8'd1;
    end
  end
`else
  assign o_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: behavioural FIFO source, pop recorder, linear checks.
// Packet-boundary checks are active when STREAM_LAST_EN is defined.
module tb_fifo_rd_stream;

  logic        rclk = 1'b0;
  logic        rrst;
  logic        empty;
  logic [7:0]  rdata = 8'h00;
  logic        r_en;
  logic        flush;
  logic        o_valid;
  logic        o_ready;
  logic [7:0]  o_data;
  logic        o_last;
  logic [15:0] o_count;

  int tests = 0;
  int fails = 0;

  // FIFO source model: words mem[rd_ptr..wr_cnt-1] are available.
  logic [7:0] mem [256];
  int rd_ptr = 0;
  int wr_cnt = 0;
  int rd_n   = 0;

  // Pop recorder.
  logic [7:0] pop_data [1024];
  logic       pop_last [1024];
  int pop_n = 0;

  always #5 rclk = ~rclk;

  assign empty = (rd_ptr >= wr_cnt);

  always @(posedge rclk) begin
    if (r_en && !empty) begin
      rdata  <= mem[rd_ptr[7:0]];
      rd_ptr <= rd_ptr + 1;
      rd_n   <= rd_n + 1;
    end
  end

  always @(posedge rclk) begin
    if (o_valid && o_ready) begin
      pop_data[pop_n[9:0]] <= o_data;
      pop_last[pop_n[9:0]] <= o_last;
      pop_n <= pop_n + 1;
    end
  end

  fifo_rd_stream #(.DATA(8), .PKT_LEN(4)) dut (
    .rclk   (rclk),
    .rrst   (rrst),
    .empty  (empty),
    .rdata  (rdata),
    .r_en   (r_en),
    .flush  (flush),
    .o_valid(o_valid),
    .o_ready(o_ready),
    .o_data (o_data),
    .o_last (o_last),
    .o_count(o_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hold_reset();
    rrst    = 1'b0;
    flush   = 1'b0;
    o_ready = 1'b0;
    repeat (2) @(negedge rclk);
  endtask

  initial begin
    int base, p0, p1, r0, n;
    logic [31:0] exp_last;

    // ---- 1: three preloaded words, reset values, latency, r_en after empty ----
    hold_reset();
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
    wr_cnt = 3;
    @(negedge rclk);
    check("rst_ren",   32'(r_en),    32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_data",  32'(o_data),  32'd0);
    check("rst_last",  32'(o_last),  32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    o_ready = 1'b1;
    rrst    = 1'b1;
    #1 check("hold_ren", 32'(r_en), 32'd0);
    @(negedge rclk);
    check("run_ren", 32'(r_en), 32'd1);
    @(negedge rclk);
    check("lat_valid0", 32'(o_valid), 32'd0);
    @(negedge rclk);
    check("t1_valid0", 32'(o_valid), 32'd1);
    check("t1_data0",  32'(o_data),  32'h11);
    check("t1_last0",  32'(o_last),  32'd0);
    @(negedge rclk);
    check("t1_valid1", 32'(o_valid), 32'd1);
    check("t1_data1",  32'(o_data),  32'h22);
    @(negedge rclk);
    check("t1_valid2", 32'(o_valid), 32'd1);
    check("t1_data2",  32'(o_data),  32'h33);
    @(negedge rclk);
    check("t1_valid_end", 32'(o_valid), 32'd0);
    check("t1_count",     32'(o_count), 32'd3);
    check("t1_ren_empty", 32'(r_en),    32'd0);
    $display("[TB] txn preload3: count=%0d", o_count);

    // ---- 2: backpressure with 8 words queued ----
    hold_reset();
    base = rd_ptr;
    for (int i = 0; i < 8; i++) mem[(base + i) % 256] = 8'(8'hA0 + i);
    wr_cnt = base + 8;
    r0 = rd_n;
    rrst = 1'b1;
    repeat (10) @(negedge rclk);
    check("bp_reads", 32'(rd_n - r0), 32'd2);
    check("bp_valid", 32'(o_valid),   32'd1);
    check("bp_hold",  32'(o_data),    32'hA0);
    check("bp_ren",   32'(r_en),      32'd0);
    o_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("bp_stream_valid", 32'(o_valid), 32'd1);
      check("bp_stream_data",  32'(o_data),  32'(8'hA0 + i));
      @(negedge rclk);
    end
    check("bp_done_valid", 32'(o_valid), 32'd0);
    check("bp_done_count", 32'(o_count), 32'd8);
    $display("[TB] txn backpressure: count=%0d", o_count);

    // ---- 3: o_ready toggling, sequence 0x00..0x0F intact ----
    hold_reset();
    base = rd_ptr;
    for (int i = 0; i < 40; i++) mem[(base + i) % 256] = 8'(i);
    wr_cnt = base + 40;
    p0 = pop_n;
    o_ready = 1'b1;
    rrst = 1'b1;
    n = 0;
    while ((pop_n - p0) < 16 && n < 200) begin
      @(negedge rclk);
      o_ready = ~o_ready;
      n++;
    end
    check("tog_done", 32'((pop_n - p0) >= 16), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check("tog_word", 32'(pop_data[(p0 + i) & 1023]), 32'(i));
`ifdef STREAM_LAST_EN
      exp_last = 32'((i % 4) == 3);
`else
      exp_last = 32'd0;
`endif
      check("tog_last", 32'(pop_last[(p0 + i) & 1023]), exp_last);
    end
    $display("[TB] txn toggle: popped=%0d", pop_n - p0);

    // ---- 4: flush with full buffer and a read launched in the flush cycle ----
    hold_reset();
    base = rd_ptr;
    for (int i = 0; i < 8; i++) mem[(base + i) % 256] = 8'(8'h50 + i);
    wr_cnt = base + 8;
    rrst = 1'b1;
    repeat (6) @(negedge rclk);
    check("fl_pre_valid", 32'(o_valid), 32'd1);
    check("fl_pre_data",  32'(o_data),  32'h50);
    check("fl_pre_count", 32'(o_count), 32'd0);
    flush   = 1'b1;
    o_ready = 1'b1;
    #1 check("fl_ren_inflight", 32'(r_en), 32'd1);
    @(negedge rclk);
    flush = 1'b0;
    #1;
    check("fl_valid", 32'(o_valid), 32'd0);
    check("fl_ren",   32'(r_en),    32'd0);
    check("fl_count", 32'(o_count), 32'd1);
    n = 0;
    while (!o_valid && n < 20) begin
      @(negedge rclk);
      n++;
    end
    check("fl_resume",    32'(o_valid), 32'd1);
    check("fl_next_word", 32'(o_data),  32'h53);
    check("fl_count_kept", 32'(o_count), 32'd1);
    @(negedge rclk);
    check("fl_next_word2", 32'(o_data),  32'h54);
    check("fl_count2",     32'(o_count), 32'd2);
    $display("[TB] txn flush: next=0x%0h count=%0d", o_data, o_count);

    // ---- 5: o_count wrap ----
    hold_reset();
    base = rd_ptr;
    wr_cnt = base + 70000;
    o_ready = 1'b1;
    rrst = 1'b1;
    n = 0;
    while (o_count != 16'hFFFF && n < 70000) begin
      @(negedge rclk);
      n++;
    end
    check("wrap_ffff", 32'(o_count), 32'h0000FFFF);
    @(negedge rclk);
    check("wrap_0000", 32'(o_count), 32'h00000000);
    @(negedge rclk);
    check("wrap_0001", 32'(o_count), 32'h00000001);
    $display("[TB] txn wrap: count=0x%0h", o_count);

`ifdef STREAM_LAST_EN
    // ---- 6: packet boundaries, then flush mid-packet ----
    hold_reset();
    base = rd_ptr;
    wr_cnt = base + 40;
    p0 = pop_n;
    o_ready = 1'b1;
    rrst = 1'b1;
    n = 0;
    while ((pop_n - p0) < 9 && n < 50) begin
      @(negedge rclk);
      n++;
    end
    check("pkt_done", 32'((pop_n - p0) >= 9), 32'd1);
    for (int i = 0; i < 9; i++) begin
      check("pkt_last", 32'(pop_last[(p0 + i) & 1023]), 32'(i == 3 || i == 7));
    end
    hold_reset();
    base = rd_ptr;
    wr_cnt = base + 40;
    p0 = pop_n;
    o_ready = 1'b1;
    rrst = 1'b1;
    n = 0;
    while ((pop_n - p0) < 6 && n < 50) begin
      @(negedge rclk);
      n++;
    end
    check("pkt_six", 32'(pop_n - p0), 32'd6);
    o_ready = 1'b0;
    flush   = 1'b1;
    @(negedge rclk);
    flush   = 1'b0;
    o_ready = 1'b1;
    p1 = pop_n;
    n = 0;
    while ((pop_n - p1) < 4 && n < 50) begin
      @(negedge rclk);
      n++;
    end
    check("pkt_post_done", 32'((pop_n - p1) >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("pkt_post_last", 32'(pop_last[(p1 + i) & 1023]), 32'(i == 3));
    end
    $display("[TB] txn packet: post-flush pops=%0d", pop_n - p1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
